// File: rtl/mse_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// mse_pkg
// Shared types and width helpers for the MSE accumulator slice.
//   state_t    : control FSM states (IDLE, RUN, DRAIN, DONE)
//   DRAIN_CYC  : cycles spent in DRAIN before the result is presented
//   diff_width : signed difference width for a given sample width
//   sq_width   : unsigned square width for a given sample width
//   cnt_width  : sample counter width able to hold 0..NUM_SAMPLES
// -----------------------------------------------------------------------------
package mse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DRAIN_CYC = 2;

  function automatic int diff_width(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int sq_width(input int data_w);
    return 2 * data_w + 2;
  endfunction

  function automatic int cnt_width(input int num_samples);
    return $clog2(num_samples + 1);
  endfunction

endpackage

// File: rtl/mse_accumulator_if.sv
// -----------------------------------------------------------------------------
// mse_accumulator_if
// Sample / control / result bundle between the PC control block and the
// MSE accumulator.
//   start      : one-cycle pulse that opens a measurement window
//   smp_valid  : ref_data/dut_data pair valid this cycle
//   ref_data   : signed reference sample
//   dut_data   : signed emulated (quantised) sample
//   busy       : accumulator is inside a window (through the result cycle)
//   mse_valid  : one-cycle result strobe
//   mse_data   : accumulated squared error, zero-extended to 64 bits
// Modports: master = control block / stream source, slave = accumulator.
// -----------------------------------------------------------------------------
interface mse_accumulator_if #(
  parameter int DATA_W = 16
);

  logic                     start;
  logic                     smp_valid;
  logic signed [DATA_W-1:0] ref_data;
  logic signed [DATA_W-1:0] dut_data;
  logic                     busy;
  logic                     mse_valid;
  logic [63:0]              mse_data;

  modport master (
    output start, smp_valid, ref_data, dut_data,
    input  busy, mse_valid, mse_data
  );

  modport slave (
    input  start, smp_valid, ref_data, dut_data,
    output busy, mse_valid, mse_data
  );

endinterface

// File: rtl/mse_accumulator_sq_err_pipe.sv
// -----------------------------------------------------------------------------
// sq_err_pipe
// Two registered stages of the squared-error datapath. The valid bit travels
// alongside the data so gaps in the input stream simply propagate as bubbles.
//   clk, rstn  : clock, asynchronous active-low reset
//   soft_rstn  : synchronous active-low clear (flushes in-flight samples)
//   in_valid   : sample pair accepted this cycle
//   ref_data   : signed reference sample
//   dut_data   : signed emulated sample
//   sq_valid   : sq carries a valid squared error
//   sq         : (ref - dut)^2, unsigned
// -----------------------------------------------------------------------------
module sq_err_pipe
  import mse_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              soft_rstn,
  input  logic                              in_valid,
  input  logic signed [DATA_W-1:0]          ref_data,
  input  logic signed [DATA_W-1:0]          dut_data,
  output logic                              sq_valid,
  output logic [sq_width(DATA_W)-1:0]       sq
);

  localparam int DIFF_W = diff_width(DATA_W);
  localparam int SQ_W   = sq_width(DATA_W);

  logic signed [DIFF_W-1:0] diff;
  logic                     diff_valid;
  logic signed [SQ_W-1:0]   prod;

  // Both operands are sign-extended to SQ_W first so the product is formed at
  // full width; a square is never negative, so the signed result is reused
  // as an unsigned magnitude.
  assign prod = SQ_W'(diff) * SQ_W'(diff);

  // Stage 1: sign-extend both samples by one bit and subtract, so the full
  // range of ref - dut (e.g. -32768 - 32767) fits without overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      diff       <= '0;
      diff_valid <= 1'b0;
    end else if (!soft_rstn) begin
      diff       <= '0;
      diff_valid <= 1'b0;
    end else begin
      diff_valid <= in_valid;
      if (in_valid) begin
        diff <= {ref_data[DATA_W-1], ref_data} - {dut_data[DATA_W-1], dut_data};
      end
    end
  end

  // Stage 2: square the difference.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sq       <= '0;
      sq_valid <= 1'b0;
    end else if (!soft_rstn) begin
      sq       <= '0;
      sq_valid <= 1'b0;
    end else begin
      sq_valid <= diff_valid;
      if (diff_valid) begin
        sq <= unsigned'(prod);
      end
    end
  end

endmodule

// File: rtl/mse_accumulator.sv
// -----------------------------------------------------------------------------
// mse_accumulator
// Accumulates (ref - dut)^2 over a window of NUM_SAMPLES sample pairs and
// reports the sum as a one-cycle strobe. A sample presented in cycle k that
// closes the window produces mse_valid in cycle k+4.
//   clk        : system clock
//   rstn       : asynchronous active-low reset
//   soft_rstn  : synchronous active-low clear; discards any in-flight window
//   bus        : mse_accumulator_if.slave (start, samples, busy, result)
// Parameters: DATA_W (sample width), NUM_SAMPLES (window length),
//             ACC_W (accumulator width, result zero-extended to 64 bits).
// Build option: define MSE_SAT_EN to make the accumulator saturate at
// 2^ACC_W-1 instead of wrapping modulo 2^ACC_W.
// -----------------------------------------------------------------------------
module mse_accumulator
  import mse_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_SAMPLES = 1024,
  parameter int ACC_W       = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            soft_rstn,
  mse_accumulator_if.slave bus
);

  localparam int SQ_W  = sq_width(DATA_W);
  localparam int CNT_W = cnt_width(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  state_t           state;
  logic [CNT_W-1:0] smp_cnt;
  logic [1:0]       drain_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic             in_valid;
  logic             start_accept;
  logic             sq_valid;
  logic [SQ_W-1:0]  sq;

  // Samples only enter the pipe while a window is open; anything after the
  // last window sample is dropped here.
  assign in_valid     = (state == RUN) && bus.smp_valid;
  assign start_accept = (state == IDLE) && bus.start;

  sq_err_pipe #(
    .DATA_W (DATA_W)
  ) u_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .soft_rstn (soft_rstn),
    .in_valid  (in_valid),
    .ref_data  (bus.ref_data),
    .dut_data  (bus.dut_data),
    .sq_valid  (sq_valid),
    .sq        (sq)
  );

`ifdef MSE_SAT_EN
  // One extra carry bit detects overflow; once pinned at all-ones the sum
  // stays there because every further term is non-negative.
  logic [ACC_W:0] acc_sum;
  assign acc_sum  = {1'b0, acc} + (ACC_W+1)'(sq);
  assign acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
`else
  assign acc_next = acc + ACC_W'(sq);
`endif

  // Stage 3: accumulator. Cleared when a window opens so a new measurement
  // never inherits the previous sum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
    end else if (!soft_rstn) begin
      acc <= '0;
    end else if (start_accept) begin
      acc <= '0;
    end else if (sq_valid) begin
      acc <= acc_next;
    end
  end

  // Control FSM with registered outputs. DRAIN counts 0..DRAIN_CYC: the first
  // two cycles let the last sample leave S1 and S2, the final one lets it land
  // in the accumulator, so the result is loaded on the edge into DONE and
  // mse_valid is high for exactly the DONE cycle. start is only honoured from
  // IDLE, which makes it ignored in RUN, DRAIN and DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      smp_cnt   <= '0;
      drain_cnt <= '0;
      bus.busy      <= 1'b0;
      bus.mse_valid <= 1'b0;
      bus.mse_data  <= '0;
    end else if (!soft_rstn) begin
      state     <= IDLE;
      smp_cnt   <= '0;
      drain_cnt <= '0;
      bus.busy      <= 1'b0;
      bus.mse_valid <= 1'b0;
      bus.mse_data  <= '0;
    end else begin
      bus.mse_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RUN;
            smp_cnt  <= '0;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          if (bus.smp_valid) begin
            if (smp_cnt == LAST_IDX) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end else begin
              smp_cnt <= smp_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'(DRAIN_CYC)) begin
            state         <= DONE;
            bus.mse_valid <= 1'b1;
            bus.mse_data  <= 64'(acc);
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
